vip_hyper_phy_resp: RTL and testbench
=====================================

VIP_HYPER_PHY_RESP -- requirements
Module: vip_hyper_phy_resp

Interface
REQ-001 Param MemBytes, default 65536: byte depth of the internal array; power of two.
REQ-002 Param LatencyCk, default 6: initial-latency count in ck cycles, fixed 2x (REQ-013).
REQ-003 Param IdReg0, default 16'h0C81: value returned on any register-space read.
REQ-004 clk_i  in  1  sampling clock, at least 4x the hyper_ck_i frequency.
REQ-005 rst_ni  in  1  reset; one clock, asynchronous, active-low.
REQ-006 hyper_cs_ni  in  1  chip select, active-low.
REQ-007 hyper_ck_i  in  1  HyperBus CK from the controller PHY; sampled as data.
REQ-008 hyper_dq_i / hyper_dq_oe_i  in  8/1  controller DQ and its output enable.
REQ-009 hyper_rwds_i / hyper_rwds_oe_i  in  1/1  controller RWDS (write mask) and its output enable.
REQ-010 hyper_dq_o / hyper_dq_oe_o  out  8/1  responder DQ and its output enable.
REQ-011 hyper_rwds_o / hyper_rwds_oe_o  out  1/1  responder RWDS and its output enable.

Function
REQ-012 ck_i is registered twice; each detected edge (rise or fall) is one transfer beat; the beat is processed in the clk_i cycle after detection.
REQ-013 FSM states IDLE, CA, LAT, RD, WR; cs_ni falling moves IDLE->CA with beat counter 0; in CA, rwds_oe_o=1, rwds_o=1 (fixed 2x latency).
REQ-014 CA: 6 beats shifted MSB-first into a 48-bit register; CA[47]=read, CA[46]=register space, CA[45]=linear burst; word address = {CA[44:16], CA[2:0]}.
REQ-015 After beat 6: register-space write -> WR with zero latency; otherwise -> LAT, counting 4*LatencyCk beats (2x latency, 2 beats per ck) before RD or WR.
REQ-016 RD: per beat, dq_oe_o=1, rwds_oe_o=1; even beat drives word[15:8] with rwds_o=1, odd beat drives word[7:0] with rwds_o=0; outputs change in the same cycle as beat processing.
REQ-017 WR: per beat, capture hyper_dq_i into the current byte unless hyper_rwds_i=1 (masked); register-space write data is discarded.
REQ-018 Word address increments after each odd beat; linear burst wraps modulo MemBytes/2; wrapped burst (CA[45]=0) wraps inside the aligned 16-word group.
REQ-019 Register-space reads return IdReg0 for every word.
REQ-020 cs_ni rising in any state -> IDLE next cycle; all OE outputs low; completed write bytes kept, partial beats dropped.
REQ-021 ck edge while cs_ni=1 is ignored; beats in LAT are counted but carry no data.
REQ-022 Memory contents unaffected by reset; initialised to zero at time 0.

Reset
REQ-023 rst_ni low: FSM IDLE, counters and CA register zero, dq_o=0, dq_oe_o=0, rwds_o=0, rwds_oe_o=0, edge-detect flops zero.
REQ-024 Reset asserted mid-burst aborts the transaction; after release the block waits for a fresh cs_ni falling edge.

Configuration
REQ-025 Macro VIP_HYPER_RESP_ASSERT_EN: when defined, protocol assertions are compiled in (dq_oe_i and dq_oe_o both high; cs_ni rising after an odd data beat; two ck edges closer than 2 clk_i cycles; dq_oe_i high during RD); when undefined, no assertions and identical functional behaviour.

Structure
REQ-026 Package vip_hyper_resp_pkg holds the FSM state enum, the 48-bit CA struct typedef, and constants CaBeats=6, WrapWords=16.
REQ-027 One sub-module vip_hyper_resp_edge_det (2-flop sync plus edge pulse); memory array and FSM in the top.

Verification
REQ-028 Write CA for word 0x10, linear, 4 bytes 0xDE 0xAD 0xBE 0xEF, rwds_i=0 -> mem bytes 0x20..0x23 equal DE AD BE EF.
REQ-029 Read CA word 0x10 -> after 24 latency beats, dq_o yields DE,AD,BE,EF with rwds_o 1,0,1,0.
REQ-030 Write 0x11,0x22 with rwds_i=1 on the first beat to word 0x10 -> mem 0x20 unchanged (DE), 0x21=0x22.
REQ-031 Wrapped read from word 0x1E, 4 words -> word order 0x1E,0x1F,0x10,0x11.
REQ-032 Register read (CA[46]=1) -> every word returns 0x0C81; register write -> no latency, memory unchanged.
REQ-033 cs_ni raised after 3 write data beats, then rst_ni pulsed mid-CA -> first 2 bytes stored, third dropped; all outputs 0; next transaction completes normally.

Source files
------------

// File: rtl/vip_hyper_resp_pkg.sv
// rtl/vip_hyper_resp_pkg.sv - shared types and constants for the HyperBus responder VIP
package vip_hyper_resp_pkg;

    // Number of command/address beats (48 bits, one byte per beat)
    localparam int unsigned CaBeats   = 6;
    // Word group size for wrapped bursts
    localparam int unsigned WrapWords = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CA,
        ST_LAT,
        ST_RD,
        ST_WR
    } state_e;

    // Command/address word, MSB first on the bus
    typedef struct packed {
        logic        read;       // 1 = read transaction
        logic        reg_space;  // 1 = register space
        logic        linear;     // 1 = linear burst, 0 = wrapped burst
        logic [28:0] addr_hi;    // upper word address
        logic [12:0] rsvd;       // ignored
        logic [2:0]  addr_lo;    // lower word address
    } ca_t;

endpackage

// File: rtl/vip_hyper_resp_edge_det.sv
// rtl/vip_hyper_resp_edge_det.sv - two-flop synchroniser with any-edge pulse
//
// Ports:
//   clk_i   in  sampling clock
//   rst_ni  in  asynchronous active-low reset
//   sig_i   in  asynchronous signal to sample (HyperBus CK)
//   edge_o  out one-cycle pulse for each rising or falling edge of sig_i
module vip_hyper_resp_edge_det (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic sig_i,
    output logic edge_o
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;

    always_comb begin
        sync1_d = sig_i;
        sync2_d = sync1_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    assign edge_o = sync1_q ^ sync2_q;

endmodule

// File: rtl/vip_hyper_phy_resp.sv
// rtl/vip_hyper_phy_resp.sv - HyperRAM responder model sampling HyperBus from a fast clock
//
// Parameters:
//   MemBytes   byte depth of the internal array (power of two)
//   LatencyCk  initial latency in CK cycles, always applied doubled
//   IdReg0     value returned for every register-space read word
// Ports:
//   clk_i, rst_ni                     sampling clock (>= 4x CK), async active-low reset
//   hyper_cs_ni                       chip select, active-low
//   hyper_ck_i                        HyperBus CK, sampled as data; each edge is one beat
//   hyper_dq_i, hyper_dq_oe_i         controller DQ and output enable
//   hyper_rwds_i, hyper_rwds_oe_i     controller RWDS (write byte mask) and output enable
//   hyper_dq_o, hyper_dq_oe_o         responder DQ and output enable
//   hyper_rwds_o, hyper_rwds_oe_o     responder RWDS and output enable
// Build option:
//   VIP_HYPER_RESP_ASSERT_EN          compiles in protocol assertions
module vip_hyper_phy_resp
    import vip_hyper_resp_pkg::*;
#(
    parameter int unsigned MemBytes  = 65536,
    parameter int unsigned LatencyCk = 6,
    parameter logic [15:0] IdReg0    = 16'h0C81
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       hyper_cs_ni,
    input  logic       hyper_ck_i,
    input  logic [7:0] hyper_dq_i,
    input  logic       hyper_dq_oe_i,
    input  logic       hyper_rwds_i,
    input  logic       hyper_rwds_oe_i,
    output logic [7:0] hyper_dq_o,
    output logic       hyper_dq_oe_o,
    output logic       hyper_rwds_o,
    output logic       hyper_rwds_oe_o
);

    localparam int unsigned       ByteAw   = $clog2(MemBytes);
    localparam int unsigned       WordAw   = ByteAw - 1;
    localparam logic [15:0]       LatBeats = 16'(4 * LatencyCk);
    localparam logic [WordAw-1:0] WrapMask = WordAw'(WrapWords - 1);

    state_e            state_q,   state_d;
    logic [15:0]       cnt_q,     cnt_d;
    ca_t               ca_q,      ca_d;
    logic [WordAw-1:0] waddr_q,   waddr_d;
    logic              linear_q,  linear_d;
    logic              reg_q,     reg_d;
    logic              read_q,    read_d;
    logic [7:0]        hi_byte_q, hi_byte_d;
    logic              hi_mask_q, hi_mask_d;
    logic [7:0]        dq_q,      dq_d;
    logic              dq_oe_q,   dq_oe_d;
    logic              rwds_q,    rwds_d;
    logic              rwds_oe_q, rwds_oe_d;
    logic              cs_n_prev_q, cs_n_prev_d;

    logic              ck_beat;
    logic              cs_fall, cs_rise, beat_en;
    ca_t               ca_new;
    logic [31:0]       ca_word;
    logic [WordAw-1:0] waddr_inc, waddr_next;
    logic [7:0]        rd_hi, rd_lo;
    logic              we_hi, we_lo;

    // Contents survive reset; zero only at time 0
    logic [7:0] mem_q [MemBytes] = '{default: 8'h00};

    vip_hyper_resp_edge_det u_ck_edge (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .sig_i  (hyper_ck_i),
        .edge_o (ck_beat)
    );

    // cs_n_prev_q resets low so a chip select already held low at reset
    // release is not mistaken for a fresh falling edge.
    assign cs_fall = cs_n_prev_q & ~hyper_cs_ni;
    assign cs_rise = ~cs_n_prev_q & hyper_cs_ni;
    assign beat_en = ck_beat & ~hyper_cs_ni;

    assign waddr_inc  = waddr_q + WordAw'(1);
    assign waddr_next = linear_q ? waddr_inc
                                 : ((waddr_q & ~WrapMask) | (waddr_inc & WrapMask));

    assign rd_hi = reg_q ? IdReg0[15:8] : mem_q[{waddr_q, 1'b0}];
    assign rd_lo = reg_q ? IdReg0[7:0]  : mem_q[{waddr_q, 1'b1}];

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ca_d        = ca_q;
        waddr_d     = waddr_q;
        linear_d    = linear_q;
        reg_d       = reg_q;
        read_d      = read_q;
        hi_byte_d   = hi_byte_q;
        hi_mask_d   = hi_mask_q;
        dq_d        = dq_q;
        dq_oe_d     = dq_oe_q;
        rwds_d      = rwds_q;
        rwds_oe_d   = rwds_oe_q;
        cs_n_prev_d = hyper_cs_ni;
        we_hi       = 1'b0;
        we_lo       = 1'b0;
        ca_new      = ca_t'({ca_q[39:0], hyper_dq_i});
        ca_word     = {ca_new.addr_hi, ca_new.addr_lo};

        if (cs_rise) begin
            // Abort whatever is in flight; a pending even write byte is dropped
            state_d   = ST_IDLE;
            cnt_d     = '0;
            dq_d      = '0;
            dq_oe_d   = 1'b0;
            rwds_d    = 1'b0;
            rwds_oe_d = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (cs_fall) begin
                        state_d   = ST_CA;
                        cnt_d     = '0;
                        ca_d      = '0;
                        rwds_oe_d = 1'b1;
                        rwds_d    = 1'b1;   // signals the fixed doubled latency
                    end
                end
                ST_CA: begin
                    if (beat_en) begin
                        ca_d = ca_new;
                        if (cnt_q == 16'(CaBeats - 1)) begin
                            cnt_d     = '0;
                            waddr_d   = ca_word[WordAw-1:0];
                            linear_d  = ca_new.linear;
                            reg_d     = ca_new.reg_space;
                            read_d    = ca_new.read;
                            rwds_oe_d = 1'b0;
                            rwds_d    = 1'b0;
                            state_d   = (!ca_new.read && ca_new.reg_space) ? ST_WR : ST_LAT;
                        end else begin
                            cnt_d = cnt_q + 16'd1;
                        end
                    end
                end
                ST_LAT: begin
                    if (beat_en) begin
                        if (cnt_q == LatBeats - 16'd1) begin
                            cnt_d   = '0;
                            state_d = read_q ? ST_RD : ST_WR;
                        end else begin
                            cnt_d = cnt_q + 16'd1;
                        end
                    end
                end
                ST_RD: begin
                    if (beat_en) begin
                        dq_oe_d   = 1'b1;
                        rwds_oe_d = 1'b1;
                        cnt_d     = cnt_q + 16'd1;
                        if (!cnt_q[0]) begin
                            dq_d   = rd_hi;
                            rwds_d = 1'b1;
                        end else begin
                            dq_d    = rd_lo;
                            rwds_d  = 1'b0;
                            waddr_d = waddr_next;
                        end
                    end
                end
                ST_WR: begin
                    if (beat_en) begin
                        cnt_d = cnt_q + 16'd1;
                        if (!cnt_q[0]) begin
                            // Hold the even byte until its word completes
                            hi_byte_d = hyper_dq_i;
                            hi_mask_d = hyper_rwds_i;
                        end else begin
                            we_hi   = ~reg_q & ~hi_mask_q;
                            we_lo   = ~reg_q & ~hyper_rwds_i;
                            waddr_d = waddr_next;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            ca_q        <= '0;
            waddr_q     <= '0;
            linear_q    <= 1'b0;
            reg_q       <= 1'b0;
            read_q      <= 1'b0;
            hi_byte_q   <= '0;
            hi_mask_q   <= 1'b0;
            dq_q        <= '0;
            dq_oe_q     <= 1'b0;
            rwds_q      <= 1'b0;
            rwds_oe_q   <= 1'b0;
            cs_n_prev_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ca_q        <= ca_d;
            waddr_q     <= waddr_d;
            linear_q    <= linear_d;
            reg_q       <= reg_d;
            read_q      <= read_d;
            hi_byte_q   <= hi_byte_d;
            hi_mask_q   <= hi_mask_d;
            dq_q        <= dq_d;
            dq_oe_q     <= dq_oe_d;
            rwds_q      <= rwds_d;
            rwds_oe_q   <= rwds_oe_d;
            cs_n_prev_q <= cs_n_prev_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (we_hi) mem_q[{waddr_q, 1'b0}] <= hi_byte_q;
        if (we_lo) mem_q[{waddr_q, 1'b1}] <= hyper_dq_i;
    end

    assign hyper_dq_o      = dq_q;
    assign hyper_dq_oe_o   = dq_oe_q;
    assign hyper_rwds_o    = rwds_q;
    assign hyper_rwds_oe_o = rwds_oe_q;

    logic unused_ok;
    assign unused_ok = ^{hyper_dq_oe_i, hyper_rwds_oe_i, ca_q[47:40], ca_word};

`ifdef VIP_HYPER_RESP_ASSERT_EN
    a_dq_contention: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(hyper_dq_oe_i && hyper_dq_oe_o));
    a_cs_whole_word: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (cs_rise && (state_q == ST_RD || state_q == ST_WR)) |-> !cnt_q[0]);
    a_ck_spacing: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(ck_beat && $past(ck_beat)));
    a_rd_no_drive: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (state_q == ST_RD) |-> !hyper_dq_oe_i);
`endif

endmodule

// File: tb/tb_vip_hyper_phy_resp.sv
// tb/tb_vip_hyper_phy_resp.sv - scoreboard bench for the HyperBus responder
module tb_vip_hyper_phy_resp;

    localparam int          MemBytes  = 256;
    localparam int          Words     = MemBytes / 2;
    localparam int          LatencyCk = 6;
    localparam logic [15:0] IdReg     = 16'h0C81;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic       hyper_cs_ni;
    logic       hyper_ck_i;
    logic [7:0] hyper_dq_i;
    logic       hyper_dq_oe_i;
    logic       hyper_rwds_i;
    logic       hyper_rwds_oe_i;
    logic [7:0] hyper_dq_o;
    logic       hyper_dq_oe_o;
    logic       hyper_rwds_o;
    logic       hyper_rwds_oe_o;

    int         errors = 0;
    int         checks = 0;
    logic [7:0] model_mem [MemBytes];
    logic [8:0] sb_q [$];
    logic [8:0] exp_beat;
    logic [7:0] wdat [64];
    logic       wmsk [64];
    logic [7:0] id_hi, id_lo;

    always #5 clk_i = ~clk_i;

    vip_hyper_phy_resp #(
        .MemBytes  (MemBytes),
        .LatencyCk (LatencyCk),
        .IdReg0    (IdReg)
    ) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .hyper_cs_ni     (hyper_cs_ni),
        .hyper_ck_i      (hyper_ck_i),
        .hyper_dq_i      (hyper_dq_i),
        .hyper_dq_oe_i   (hyper_dq_oe_i),
        .hyper_rwds_i    (hyper_rwds_i),
        .hyper_rwds_oe_i (hyper_rwds_oe_i),
        .hyper_dq_o      (hyper_dq_o),
        .hyper_dq_oe_o   (hyper_dq_oe_o),
        .hyper_rwds_o    (hyper_rwds_o),
        .hyper_rwds_oe_o (hyper_rwds_oe_o)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every CK edge is followed by a settled sample well before the next edge
    initial begin
        forever begin
            @(hyper_ck_i);
            repeat (3) @(posedge clk_i);
            @(negedge clk_i);
            if (hyper_dq_oe_o) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rd_unexpected: got dq=%02h rwds=%0b with no expected beat",
                             hyper_dq_o, hyper_rwds_o);
                end else begin
                    exp_beat = sb_q.pop_front();
                    check("rd_beat", {hyper_rwds_o, hyper_dq_o}, exp_beat);
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    // One bus beat: data and CK change together, held for four sampling clocks
    task automatic beat(input logic [7:0] d, input logic r);
        hyper_dq_i   = d;
        hyper_rwds_i = r;
        hyper_ck_i   = ~hyper_ck_i;
        repeat (4) @(posedge clk_i);
        #1;
    endtask

    function automatic int word_at(input int base, input logic lin, input int k);
        if (lin) return (base + k) % Words;
        return ((base & ~(16 - 1)) | ((base + k) & (16 - 1))) % Words;
    endfunction

    task automatic send_ca(input logic rd, input logic regsp, input logic lin, input logic [31:0] waddr);
        logic [47:0] ca;
        ca = {rd, regsp, lin, waddr[31:3], 13'($urandom), waddr[2:0]};
        hyper_cs_ni     = 1'b0;
        hyper_dq_oe_i   = 1'b1;
        hyper_rwds_oe_i = 1'b0;
        idle(2);
        check("ca_rwds", {hyper_rwds_oe_o, hyper_rwds_o}, 2'b11);
        for (int i = 0; i < 6; i++) beat(ca[47-8*i -: 8], 1'b0);
    endtask

    task automatic do_write(input logic regsp, input logic lin, input logic [31:0] waddr, input int nbeats);
        int base;
        int a;
        base = int'(waddr % 32'(Words));
        send_ca(1'b0, regsp, lin, waddr);
        if (!regsp) repeat (4 * LatencyCk) beat(8'($urandom), 1'b0);
        hyper_rwds_oe_i = 1'b1;
        for (int i = 0; i < nbeats; i++) beat(wdat[i], wmsk[i]);
        idle(2);
        hyper_cs_ni     = 1'b1;
        hyper_dq_oe_i   = 1'b0;
        hyper_rwds_oe_i = 1'b0;
        idle(3);
        if (!regsp) begin
            for (int w = 0; w < nbeats / 2; w++) begin
                a = word_at(base, lin, w);
                if (!wmsk[2*w])   model_mem[2*a]   = wdat[2*w];
                if (!wmsk[2*w+1]) model_mem[2*a+1] = wdat[2*w+1];
            end
        end
    endtask

    task automatic do_read(input logic regsp, input logic lin, input logic [31:0] waddr, input int nwords);
        int base;
        int a;
        base = int'(waddr % 32'(Words));
        for (int w = 0; w < nwords; w++) begin
            a = word_at(base, lin, w);
            sb_q.push_back({1'b1, regsp ? id_hi : model_mem[2*a]});
            sb_q.push_back({1'b0, regsp ? id_lo : model_mem[2*a+1]});
        end
        send_ca(1'b1, regsp, lin, waddr);
        hyper_dq_oe_i = 1'b0;
        repeat (4 * LatencyCk) beat(8'($urandom), 1'b0);
        for (int i = 0; i < 2 * nwords; i++) beat(8'($urandom), 1'b0);
        idle(2);
        hyper_cs_ni = 1'b1;
        idle(2);
        check("cs_rise_oe", {hyper_dq_oe_o, hyper_rwds_oe_o}, 2'b00);
        check("rd_pending", sb_q.size(), 0);
        sb_q.delete();
    endtask

    initial begin
        logic        lin;
        logic [31:0] a;
        int          n;
        int          nb;

        id_hi           = IdReg[15:8];
        id_lo           = IdReg[7:0];
        rst_ni          = 1'b0;
        hyper_cs_ni     = 1'b1;
        hyper_ck_i      = 1'b0;
        hyper_dq_i      = 8'h00;
        hyper_dq_oe_i   = 1'b0;
        hyper_rwds_i    = 1'b0;
        hyper_rwds_oe_i = 1'b0;
        for (int i = 0; i < MemBytes; i++) model_mem[i] = 8'h00;

        repeat (3) @(posedge clk_i);
        #1;
        check("rst_dq",      hyper_dq_o,      8'h00);
        check("rst_dq_oe",   hyper_dq_oe_o,   1'b0);
        check("rst_rwds",    hyper_rwds_o,    1'b0);
        check("rst_rwds_oe", hyper_rwds_oe_o, 1'b0);
        rst_ni = 1'b1;
        idle(2);

        // CK activity with chip select high must be ignored
        repeat (5) beat(8'hFF, 1'b0);

        // Basic linear write then read back
        wdat[0] = 8'hDE; wdat[1] = 8'hAD; wdat[2] = 8'hBE; wdat[3] = 8'hEF;
        for (int i = 0; i < 4; i++) wmsk[i] = 1'b0;
        do_write(1'b0, 1'b1, 32'h10, 4);
        do_read(1'b0, 1'b1, 32'h10, 2);

        // Masked first byte
        wdat[0] = 8'h11; wdat[1] = 8'h22; wmsk[0] = 1'b1; wmsk[1] = 1'b0;
        do_write(1'b0, 1'b1, 32'h10, 2);
        do_read(1'b0, 1'b1, 32'h10, 1);

        // Fill the 16-word group at 0x10 and read wrapped from 0x1E
        for (int i = 0; i < 32; i++) begin
            wdat[i] = 8'($urandom);
            wmsk[i] = 1'b0;
        end
        do_write(1'b0, 1'b1, 32'h10, 32);
        do_read(1'b0, 1'b0, 32'h1E, 4);

        // Linear burst across the top of the array
        do_read(1'b0, 1'b1, 32'h7F, 3);

        // Register space: reads return the ID, writes leave memory alone
        do_read(1'b1, 1'b0, 32'h10, 3);
        for (int i = 0; i < 4; i++) begin
            wdat[i] = 8'($urandom);
            wmsk[i] = 1'b0;
        end
        do_write(1'b1, 1'b0, 32'h10, 4);
        do_read(1'b0, 1'b1, 32'h10, 2);

        // Partial word dropped on chip-select rise, then reset mid-CA
        wdat[0] = 8'hA1; wdat[1] = 8'hA2; wdat[2] = 8'hA3;
        for (int i = 0; i < 3; i++) wmsk[i] = 1'b0;
        do_write(1'b0, 1'b1, 32'h30, 3);
        hyper_cs_ni   = 1'b0;
        hyper_dq_oe_i = 1'b1;
        idle(2);
        beat(8'h80, 1'b0);
        beat(8'h00, 1'b0);
        beat(8'h00, 1'b0);
        rst_ni = 1'b0;
        idle(2);
        check("mid_rst_dq",      hyper_dq_o,      8'h00);
        check("mid_rst_dq_oe",   hyper_dq_oe_o,   1'b0);
        check("mid_rst_rwds",    hyper_rwds_o,    1'b0);
        check("mid_rst_rwds_oe", hyper_rwds_oe_o, 1'b0);
        rst_ni = 1'b1;
        idle(1);
        repeat (3) beat(8'h80, 1'b0);
        check("post_rst_idle", {hyper_rwds_oe_o, hyper_dq_oe_o}, 2'b00);
        hyper_cs_ni   = 1'b1;
        hyper_dq_oe_i = 1'b0;
        idle(3);
        do_read(1'b0, 1'b1, 32'h30, 2);

        // Randomised traffic, every write read back
        for (int t = 0; t < 16; t++) begin
            lin = 1'($urandom);
            a   = $urandom;
            n   = $urandom_range(1, 6);
            nb  = 2 * n - (($urandom_range(0, 3) == 0) ? 1 : 0);
            for (int i = 0; i < nb; i++) begin
                wdat[i] = 8'($urandom);
                wmsk[i] = ($urandom_range(0, 3) == 0);
            end
            do_write(1'b0, lin, a, nb);
            do_read(1'b0, lin, a, n);
            if (t % 4 == 3) do_read(1'b1, 1'($urandom), $urandom, $urandom_range(1, 3));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
